// File: rtl/alu_flag_stage_if.sv
// Operand/result handshake bundle for alu_flag_stage.
// master = upstream/downstream environment, slave = the ALU stage.
interface alu_flag_stage_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [1:0]       op;
  logic [1:0]       cond;
  logic             flag_wr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             executed;
  logic             carry;
  logic             zero;
  logic             flag_c;
  logic             flag_z;

  modport master (
    output in_valid, data_a, data_b, op, cond, flag_wr, out_ready,
    input  in_ready, out_valid, result, executed, carry, zero, flag_c, flag_z
  );

  modport slave (
    input  in_valid, data_a, data_b, op, cond, flag_wr, out_ready,
    output in_ready, out_valid, result, executed, carry, zero, flag_c, flag_z
  );
endinterface

// File: rtl/alu_flag_stage.sv
// Registered ADD/NAND/SUB(/SHL) stage with architectural C/Z flags and conditional execute.
// Define ALU_SHIFT_EN to build the SHL datapath for Op 11; otherwise Op 11 never executes.
module alu_flag_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  alu_flag_stage_if.slave bus
);
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_C      = 2'b01;
  localparam logic [1:0] COND_Z      = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_executed;
  logic             r_flag_c;
  logic             r_flag_z;

  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_carry_nxt;
  logic             w_zero_nxt;
  logic             w_executed_nxt;
  logic             w_flag_c_nxt;
  logic             w_flag_z_nxt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_cond_ok;
  logic             w_op_ok;
  logic             w_exec;
  logic [WIDTH-1:0] w_alu_r;
  logic             w_alu_c;
  logic             w_alu_z;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // SUB carry is the no-borrow flag: A + ~B + 1 in WIDTH+1 bits.
  assign w_add = {1'b0, bus.data_a} + {1'b0, bus.data_b};
  assign w_sub = {1'b0, bus.data_a} + {1'b0, ~bus.data_b} + (WIDTH+1)'(1);

`ifdef ALU_SHIFT_EN
  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  logic [WIDTH:0] w_shl;
  // Bit WIDTH of the widened shift is the last bit shifted out (0 for shift 0).
  assign w_shl = {1'b0, bus.data_a} << bus.data_b[SHAMT_W-1:0];
`endif

  // Condition check against current flags and ALU result selection.
  always_comb begin
    w_cond_ok = 1'b0;
    w_op_ok   = 1'b1;
    w_alu_r   = bus.data_a;
    w_alu_c   = 1'b0;

    unique case (bus.cond)
      COND_ALWAYS: w_cond_ok = 1'b1;
      COND_C:      w_cond_ok = r_flag_c;
      COND_Z:      w_cond_ok = r_flag_z;
      COND_NEVER:  w_cond_ok = 1'b0;
    endcase

    unique case (bus.op)
      OP_ADD:  {w_alu_c, w_alu_r} = w_add;
      OP_NAND: w_alu_r = ~(bus.data_a & bus.data_b);
      OP_SUB:  {w_alu_c, w_alu_r} = w_sub;
      OP_SHL: begin
`ifdef ALU_SHIFT_EN
        {w_alu_c, w_alu_r} = w_shl;
`else
        w_op_ok = 1'b0;
`endif
      end
    endcase
  end

  assign w_alu_z = (w_alu_r == '0);
  assign w_exec  = w_cond_ok && w_op_ok;

  // Next-state for the output register and flags.
  always_comb begin
    w_out_valid_nxt = r_out_valid;
    w_result_nxt    = r_result;
    w_carry_nxt     = r_carry;
    w_zero_nxt      = r_zero;
    w_executed_nxt  = r_executed;
    w_flag_c_nxt    = r_flag_c;
    w_flag_z_nxt    = r_flag_z;

    if (w_accept) begin
      w_out_valid_nxt = 1'b1;
      w_executed_nxt  = w_exec;
      w_result_nxt    = w_exec ? w_alu_r : bus.data_a;
      w_carry_nxt     = w_exec && w_alu_c;
      w_zero_nxt      = w_exec && w_alu_z;
      if (w_exec && bus.flag_wr) begin
        w_flag_c_nxt = w_alu_c;
        w_flag_z_nxt = w_alu_z;
      end
    end else if (bus.out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_executed  <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_result    <= w_result_nxt;
      r_carry     <= w_carry_nxt;
      r_zero      <= w_zero_nxt;
      r_executed  <= w_executed_nxt;
      r_flag_c    <= w_flag_c_nxt;
      r_flag_z    <= w_flag_z_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;
  assign bus.executed  = r_executed;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_z    = r_flag_z;
endmodule
